// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with occupancy flags, sticky error flags and a choice of
// registered-read or first-word-fall-through output; any depth >= 2.
module sync_fifo_ext #(
    parameter int DATA_WIDTH   = 32,
    parameter int FIFO_DEPTH   = 16,
    parameter int AFULL_LEVEL  = 12,
    parameter int AEMPTY_LEVEL = 4,
    parameter int FWFT         = 0,
    localparam int CW          = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  clr_err,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int            PW       = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]         rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]         count_reg, count_next;
    logic                  overflow_reg, overflow_next;
    logic                  underflow_reg, underflow_next;
    logic                  push_ok, pop_ok;

    // Flags come straight from the registered count, never from push/pop.
    assign empty        = (count_reg == '0);
    assign full         = (count_reg == CW'(FIFO_DEPTH));
    assign almost_full  = (32'(count_reg) >= AFULL_LEVEL);
    assign almost_empty = (32'(count_reg) <= AEMPTY_LEVEL);
    assign count        = count_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

    always_comb begin
        pop_ok         = pop && !empty && !flush;
        push_ok        = push && !flush && (!full || pop_ok);
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        count_next     = count_reg;
        overflow_next  = overflow_reg;
        underflow_next = underflow_reg;

        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push_ok)
                wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + PW'(1);
            if (pop_ok)
                rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + PW'(1);
            if (push_ok && !pop_ok)
                count_next = count_reg + CW'(1);
            else if (pop_ok && !push_ok)
                count_next = count_reg - CW'(1);
        end

        // A fresh error in the same cycle wins over clr_err.
        if (push && !flush && !push_ok)
            overflow_next = 1'b1;
        else if (clr_err)
            overflow_next = 1'b0;
        if (pop && !flush && !pop_ok)
            underflow_next = 1'b1;
        else if (clr_err)
            underflow_next = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    // Storage is not reset; contents are discarded by clearing the pointers.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr_reg] <= din;
    end

    generate
        if (FWFT == 0) begin : g_registered
            logic [DATA_WIDTH-1:0] dout_reg;
            logic                  dout_valid_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dout_reg       <= '0;
                    dout_valid_reg <= 1'b0;
                end else begin
                    if (pop_ok)
                        dout_reg <= mem[rd_ptr_reg];
                    dout_valid_reg <= pop_ok;
                end
            end

            assign dout       = dout_reg;
            assign dout_valid = dout_valid_reg;
        end else begin : g_fwft
            // Remembers the last shown head so dout stays defined while empty.
            logic [DATA_WIDTH-1:0] hold_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    hold_reg <= '0;
                else if (!empty)
                    hold_reg <= mem[rd_ptr_reg];
            end

            assign dout       = empty ? hold_reg : mem[rd_ptr_reg];
            assign dout_valid = !empty;
        end
    endgenerate

endmodule
